// File: rtl/periph_timer_uart_tx.sv
// Memory-mapped peripheral on the MEM-stage data bus: reloadable 32-bit timer with IRQ
// and an 8N1 UART transmitter. Reads are combinational, writes commit on the clock edge.
module periph_timer_uart_tx #(
    parameter int          BAUD_DIV = 5208,
    parameter logic [31:0] BASE     = 32'h40000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        supervisor,
    output logic        irq,
    output logic        uart_tx
);

    localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BAUD_DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [29:0] word;
    logic        sel;
    logic        hit_th, hit_tl, hit_tcon, hit_txd, hit_ucon;
    logic        addr_unused;

    logic [31:0] th, tl;
    logic [2:0]  tcon;
    logic        tick, overflow;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [7:0]       tx_byte, tx_byte_n;
    logic             line, line_n;
    logic             tx_busy, tx_busy_n;
    logic             tx_done, tx_done_n;
    logic             baud_end;

    // Word offset within the block; the byte lane bits play no part in decoding.
    assign word        = addr[31:2] - BASE[31:2];
    assign sel         = addr[30];
    assign addr_unused = ^addr[1:0];
    assign hit_th      = sel && (word == 30'd0);
    assign hit_tl      = sel && (word == 30'd1);
    assign hit_tcon    = sel && (word == 30'd2);
    assign hit_txd     = sel && (word == 30'd6);
    assign hit_ucon    = sel && (word == 30'd8);

    // A bus write to TL or TCON suppresses the whole timer step for that cycle.
    assign tick     = tcon[0] && !(wr && (hit_tl || hit_tcon));
    assign overflow = (tl == 32'hFFFFFFFF);

    always_ff @(posedge clk) begin
        if (reset) begin
            th   <= '0;
            tl   <= '0;
            tcon <= '0;
        end else begin
            if (wr && hit_th)
                th <= wdata;
            if (wr && hit_tl)
                tl <= wdata;
            else if (tick)
                tl <= overflow ? th : tl + 32'd1;
            if (wr && hit_tcon)
                tcon <= wdata[2:0];
            else if (tick && overflow)
                tcon[2] <= tcon[1] | tcon[2];
        end
    end

    assign irq = tcon[1] & tcon[2] & ~supervisor;

    assign baud_end = (cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            tx_byte <= '0;
            line    <= 1'b1;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            tx_byte <= tx_byte_n;
            line    <= line_n;
            tx_busy <= tx_busy_n;
            tx_done <= tx_done_n;
        end
    end

    // The line level is registered together with the state so it moves on the same edge.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        tx_byte_n = tx_byte;
        line_n    = line;
        tx_busy_n = tx_busy;
        tx_done_n = tx_done;
        if (rd && hit_ucon)
            tx_done_n = 1'b0;
        case (state)
            IDLE: begin
                line_n = 1'b1;
                if (wr && hit_txd) begin
                    state_n   = START;
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    tx_byte_n = wdata[7:0];
                    line_n    = 1'b0;
                    tx_busy_n = 1'b1;
                    tx_done_n = 1'b0;
                end
            end
            START: begin
                if (baud_end) begin
                    cnt_n     = '0;
                    state_n   = DATA;
                    bit_idx_n = '0;
                    line_n    = tx_byte[0];
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (baud_end) begin
                    cnt_n = '0;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                        line_n  = 1'b1;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                        line_n    = tx_byte[bit_idx + 3'd1];
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (baud_end) begin
                    cnt_n     = '0;
                    state_n   = IDLE;
                    line_n    = 1'b1;
                    tx_busy_n = 1'b0;
                    tx_done_n = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = IDLE;
                line_n  = 1'b1;
            end
        endcase
    end

    assign uart_tx = line;

    always_comb begin
        rdata = '0;
        if (rd) begin
            if (hit_th)
                rdata = th;
            else if (hit_tl)
                rdata = tl;
            else if (hit_tcon)
                rdata = {29'd0, tcon};
            else if (hit_ucon)
                rdata = {30'd0, tx_done, tx_busy};
        end
    end

endmodule

// File: tb/tb_periph_timer_uart_tx.sv
// Bench for periph_timer_uart_tx: directed register/UART checks plus a randomized
// timer phase compared against an arithmetic reference model of the timer rules.
module tb_periph_timer_uart_tx;

    localparam logic [31:0] BASE   = 32'h40000000;
    localparam logic [31:0] A_TH   = BASE + 32'h00;
    localparam logic [31:0] A_TL   = BASE + 32'h04;
    localparam logic [31:0] A_TCON = BASE + 32'h08;
    localparam logic [31:0] A_TXD  = BASE + 32'h18;
    localparam logic [31:0] A_UCON = BASE + 32'h20;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd, wr;
    logic [31:0] addr, wdata, rdata;
    logic        supervisor;
    logic        irq;
    logic        uart_tx;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_th, m_tl;
    logic [2:0]  m_tcon;

    periph_timer_uart_tx #(.BAUD_DIV(4), .BASE(BASE)) dut (
        .clk        (clk),
        .reset      (reset),
        .rd         (rd),
        .wr         (wr),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .supervisor (supervisor),
        .irq        (irq),
        .uart_tx    (uart_tx)
    );

    always #5 clk = ~clk;

    // Timer reference: counts while enabled, reloads from TH after all-ones, and any
    // bus write to TL or TCON replaces that cycle's count step.
    always @(posedge clk) begin
        if (reset) begin
            m_th   <= '0;
            m_tl   <= '0;
            m_tcon <= '0;
        end else begin
            if (wr && addr == A_TH)
                m_th <= wdata;
            if (wr && addr == A_TL) begin
                m_tl <= wdata;
            end else if (wr && addr == A_TCON) begin
                m_tcon <= wdata[2:0];
            end else if (m_tcon[0]) begin
                if (m_tl == 32'hFFFFFFFF) begin
                    m_tl <= m_th;
                    if (m_tcon[1])
                        m_tcon[2] <= 1'b1;
                end else begin
                    m_tl <= m_tl + 32'd1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        wr    = 1'b1;
        addr  = a;
        wdata = d;
        @(posedge clk);
        #1;
        wr = 1'b0;
    endtask

    task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
        rd   = 1'b1;
        addr = a;
        #1;
        d = rdata;
        @(posedge clk);
        #1;
        rd = 1'b0;
    endtask

    // Sends one byte and checks every cycle of the 40-cycle frame; optionally
    // attempts a second TXD write at cycle 'inject'.
    task automatic send_check(input logic [7:0] b, input int inject);
        logic exp;
        bus_wr(A_TXD, {24'h0, b});
        for (int k = 0; k < 40; k++) begin
            if (k < 4)
                exp = 1'b0;
            else if (k < 36)
                exp = b[(k - 4) / 4];
            else
                exp = 1'b1;
            check("uart_tx_frame", {31'd0, uart_tx}, {31'd0, exp});
            if (k == inject) begin
                wr    = 1'b1;
                addr  = A_TXD;
                wdata = 32'h3C;
            end else if (k == 20) begin
                rd   = 1'b1;
                addr = A_UCON;
                #1;
                check("ucon_busy", rdata, 32'h1);
            end
            @(posedge clk);
            #1;
            wr = 1'b0;
            rd = 1'b0;
        end
        check("uart_tx_idle_after", {31'd0, uart_tx}, 32'h1);
    endtask

    initial begin
        logic [31:0] d, exp;
        int op;
        rd = 0; wr = 0; addr = 0; wdata = 0; supervisor = 0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        bus_rd(A_TH, d);   check("reset_th", d, 32'h0);
        bus_rd(A_TL, d);   check("reset_tl", d, 32'h0);
        bus_rd(A_TCON, d); check("reset_tcon", d, 32'h0);
        bus_rd(A_UCON, d); check("reset_ucon", d, 32'h0);
        check("reset_uart_tx", {31'd0, uart_tx}, 32'h1);
        check("reset_irq", {31'd0, irq}, 32'h0);

        bus_wr(A_TH, 32'hFFFFFFF0);
        bus_wr(A_TL, 32'hFFFFFFFE);
        bus_wr(A_TCON, 32'h3);
        idle_cycle();
        idle_cycle();
        check("irq_pending", {31'd0, irq}, 32'h1);
        bus_rd(A_TL, d);   check("tl_reload", d, 32'hFFFFFFF0);
        bus_rd(A_TCON, d); check("tcon_pending", d, 32'h7);
        supervisor = 1'b1;
        #1;
        check("irq_masked_supervisor", {31'd0, irq}, 32'h0);
        supervisor = 1'b0;
        #1;
        check("irq_unmasked", {31'd0, irq}, 32'h1);
        bus_wr(A_TCON, 32'h3);
        check("irq_cleared", {31'd0, irq}, 32'h0);

        addr = A_TH;
        #1;
        check("rdata_no_rd", rdata, 32'h0);
        bus_rd(A_TH, d); check("th_readback", d, 32'hFFFFFFF0);

        bus_wr(A_TL, 32'hFFFFFFFE);
        idle_cycle();
        bus_wr(A_TL, 32'h5);
        bus_rd(A_TL, d);   check("tl_write_priority", d, 32'h5);
        bus_rd(A_TCON, d); check("tcon_no_pending", d, 32'h3);

        bus_rd(BASE + 32'h10, d); check("unmapped_read", d, 32'h0);
        bus_rd(A_TXD, d);         check("txd_read_zero", d, 32'h0);
        bus_rd(32'h00000008, d);  check("unselected_read", d, 32'h0);
        bus_wr(32'h00000000, 32'h1234);
        bus_rd(A_TH, d); check("unselected_write", d, 32'hFFFFFFF0);
        bus_wr(A_TCON, 32'h0);

        for (int i = 0; i < 300; i++) begin
            supervisor = 1'($urandom_range(0, 1));
            op = int'($urandom_range(0, 6));
            case (op)
                1: bus_wr(A_TH, 32'hFFFFFF00 | $urandom_range(0, 255));
                2: bus_wr(A_TL, 32'hFFFFFFF0 | $urandom_range(0, 15));
                3: bus_wr(A_TCON, ($urandom & 32'hFFFFFFFE) | 32'($urandom_range(0, 3) != 0));
                4: begin exp = m_tl; bus_rd(A_TL, d); check("rand_tl", d, exp); end
                5: begin exp = {29'd0, m_tcon}; bus_rd(A_TCON, d); check("rand_tcon", d, exp); end
                6: begin exp = m_th; bus_rd(A_TH, d); check("rand_th", d, exp); end
                default: idle_cycle();
            endcase
            check("rand_irq", {31'd0, irq}, {31'd0, m_tcon[1] & m_tcon[2] & ~supervisor});
        end
        supervisor = 1'b0;
        bus_wr(A_TCON, 32'h0);

        send_check(8'hA5, -1);
        bus_rd(A_UCON, d); check("ucon_done", d, 32'h2);
        bus_rd(A_UCON, d); check("ucon_cleared", d, 32'h0);

        send_check(8'hA5, 10);
        for (int k = 0; k < 45; k++) begin
            check("no_restart", {31'd0, uart_tx}, 32'h1);
            idle_cycle();
        end
        bus_rd(A_UCON, d); check("ucon_done_once", d, 32'h2);
        bus_rd(A_UCON, d); check("ucon_cleared2", d, 32'h0);

        for (int r = 0; r < 2; r++) begin
            send_check(8'($urandom_range(0, 255)), -1);
            bus_rd(A_UCON, d); check("ucon_done_rand", d, 32'h2);
        end

        bus_wr(A_TXD, 32'hA5);
        repeat (12) idle_cycle();
        reset = 1'b1;
        idle_cycle();
        reset = 1'b0;
        check("reset_mid_uart_tx", {31'd0, uart_tx}, 32'h1);
        bus_rd(A_UCON, d); check("reset_mid_ucon", d, 32'h0);
        send_check(8'h01, -1);
        bus_rd(A_UCON, d); check("ucon_done_after_reset", d, 32'h2);
        bus_rd(A_UCON, d); check("ucon_cleared3", d, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
